// File: rtl/lockout_controller.sv
// Keypad lockout controller: opens the door on a correct attempt, locks the keypad
// or raises the alarm on repeated wrong attempts, and forces the door open on fire.
module lockout_controller #(
   parameter int unsigned LOCK_THRESH   = 3,
   parameter int unsigned ALARM_THRESH  = 5,
   parameter int unsigned LOCK_CYCLES   = 16,
   parameter int unsigned UNLOCK_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] count,
   input  logic       attempt_valid,
   input  logic       O,
   input  logic       fireAlarm,
   input  logic       disarm,
   output logic       door_unlock,
   output logic       locked_out,
   output logic       alarm,
   output logic       O2,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      UNLOCK  = 3'd1,
      LOCKOUT = 3'd2,
      ALARM   = 3'd3,
      FIRE    = 3'd4
   } state_t;

   localparam logic [7:0] LOCK_LD   = LOCK_CYCLES[7:0];
   localparam logic [7:0] UNLOCK_LD = UNLOCK_CYCLES[7:0];

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic       door_q, door_d;
   logic       lock_q, lock_d;
   logic       alarm_q, alarm_d;
   logic       o2_q, o2_d;
   logic [31:0] count_ext;

   assign count_ext = {29'd0, count};

   always_comb begin
      state_d = state_q;
      timer_d = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;
      o2_d    = 1'b0;
      if (fireAlarm) begin
         state_d = FIRE;
         timer_d = 8'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               timer_d = 8'd0;
               if (attempt_valid) begin
                  if (O) begin
                     state_d = UNLOCK;
                     timer_d = UNLOCK_LD;
                  end else if (count_ext >= ALARM_THRESH) begin
                     state_d = ALARM;
                  end else if (count_ext >= LOCK_THRESH) begin
                     state_d = LOCKOUT;
                     timer_d = LOCK_LD;
                  end
               end
            end
            UNLOCK, LOCKOUT: begin
               // Timer value 1 marks the last cycle of the timed window.
               if (timer_q <= 8'd1) begin
                  state_d = IDLE;
                  timer_d = 8'd0;
               end
            end
            ALARM: begin
               if (disarm) begin
                  state_d = IDLE;
                  o2_d    = 1'b1;
               end
            end
            FIRE: begin
               state_d = IDLE;
               timer_d = 8'd0;
            end
            default: begin
               state_d = IDLE;
               timer_d = 8'd0;
            end
         endcase
      end
      door_d  = (state_d == UNLOCK) || (state_d == FIRE);
      lock_d  = (state_d == LOCKOUT) || (state_d == ALARM);
      alarm_d = (state_d == ALARM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= 8'd0;
         door_q  <= 1'b0;
         lock_q  <= 1'b0;
         alarm_q <= 1'b0;
         o2_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         door_q  <= door_d;
         lock_q  <= lock_d;
         alarm_q <= alarm_d;
         o2_q    <= o2_d;
      end
   end

   assign door_unlock = door_q;
   assign locked_out  = lock_q;
   assign alarm       = alarm_q;
   assign O2          = o2_q;
   assign state       = state_q;

endmodule

// File: tb/tb_lockout_controller.sv
// Directed and random stimulus for lockout_controller, checked against a
// behavioural model built from remaining-cycle counters and mode flags.
module tb_lockout_controller;

   localparam int LOCK_T = 3, ALARM_T = 5, LOCK_C = 16, UNLOCK_C = 8;

   logic       clk = 1'b0;
   logic       rst, attempt_valid, O, fireAlarm, disarm;
   logic [2:0] count;
   logic       door_unlock, locked_out, alarm, O2;
   logic [2:0] state;

   int n_asrt = 0;
   int n_fail = 0;

   // Reference model: cycles left in each timed mode plus mode flags.
   int door_left, lock_left;
   bit m_alarm, m_fire, m_o2;

   always #5 clk = ~clk;

   lockout_controller #(
      .LOCK_THRESH(LOCK_T), .ALARM_THRESH(ALARM_T),
      .LOCK_CYCLES(LOCK_C), .UNLOCK_CYCLES(UNLOCK_C)
   ) dut (
      .clk(clk), .rst(rst), .count(count), .attempt_valid(attempt_valid), .O(O),
      .fireAlarm(fireAlarm), .disarm(disarm), .door_unlock(door_unlock),
      .locked_out(locked_out), .alarm(alarm), .O2(O2), .state(state)
   );

   function automatic int m_state();
      if (m_fire) return 4;
      if (m_alarm) return 3;
      if (lock_left > 0) return 2;
      if (door_left > 0) return 1;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         door_left = 0; lock_left = 0; m_alarm = 0; m_fire = 0; m_o2 = 0;
      end else begin
         m_o2 = 0;
         if (fireAlarm) begin
            door_left = 0; lock_left = 0; m_alarm = 0; m_fire = 1;
         end else if (m_fire) begin
            m_fire = 0;
         end else if (m_alarm) begin
            if (disarm) begin
               m_alarm = 0; m_o2 = 1;
            end
         end else if (lock_left > 0) begin
            lock_left--;
         end else if (door_left > 0) begin
            door_left--;
         end else if (attempt_valid) begin
            if (O) door_left = UNLOCK_C;
            else if (int'(count) >= ALARM_T) m_alarm = 1;
            else if (int'(count) >= LOCK_T) lock_left = LOCK_C;
         end
      end
   endtask

   task automatic tick();
      int s;
      @(posedge clk);
      model_step();
      #1;
      s = m_state();
      chk("state", 8'(state), 8'(s));
      chk("door_unlock", 8'(door_unlock), 8'((s == 1 || s == 4) ? 1 : 0));
      chk("locked_out", 8'(locked_out), 8'((s == 2 || s == 3) ? 1 : 0));
      chk("alarm", 8'(alarm), 8'((s == 3) ? 1 : 0));
      chk("O2", 8'(O2), 8'(m_o2));
   endtask

   task automatic drive(input logic r, input logic f, input logic av, input logic o,
                        input logic [2:0] c, input logic d);
      rst = r; fireAlarm = f; attempt_valid = av; O = o; count = c; disarm = d;
   endtask

   initial begin
      int d, l, p;
      door_left = 0; lock_left = 0; m_alarm = 0; m_fire = 0; m_o2 = 0;
      drive(1, 0, 0, 0, 3'd0, 0);
      tick(); tick();
      chk("reset_state", 8'(state), 8'd0);

      // Correct password: door open for UNLOCK_C cycles.
      drive(0, 0, 1, 1, 3'd0, 0); d = 0;
      tick(); d += int'(door_unlock);
      drive(0, 0, 0, 0, 3'd0, 0);
      repeat (10) begin tick(); d += int'(door_unlock); end
      chk("unlock_len", 8'(d), 8'(UNLOCK_C));

      // Lockout with a correct attempt at cycle 5 ignored.
      d = 0; l = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 0) drive(0, 0, 1, 0, 3'd3, 0);
         else if (i == 4) drive(0, 0, 1, 1, 3'd0, 0);
         else drive(0, 0, 0, 0, 3'd0, 0);
         tick();
         d += int'(door_unlock); l += int'(locked_out);
      end
      chk("lock_len", 8'(l), 8'(LOCK_C));
      chk("lock_door", 8'(d), 8'd0);

      // Alarm, then disarm held for four cycles gives one O2 pulse.
      drive(0, 0, 1, 0, 3'd5, 0); tick();
      chk("alarm_on", 8'(alarm), 8'd1);
      drive(0, 0, 0, 0, 3'd0, 0); tick(); tick();
      p = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 0, 3'd0, (i < 4) ? 1'b1 : 1'b0);
         tick(); p += int'(O2);
      end
      chk("o2_pulses", 8'(p), 8'd1);
      chk("alarm_off", 8'(alarm), 8'd0);

      // Fire preempts lockout with 10 cycles left; lockout is not resumed.
      drive(0, 0, 1, 0, 3'd4, 0); tick();
      drive(0, 0, 0, 0, 3'd0, 0);
      repeat (6) tick();
      drive(0, 1, 0, 0, 3'd0, 0); tick();
      chk("fire_state", 8'(state), 8'd4);
      chk("fire_door", 8'(door_unlock), 8'd1);
      tick();
      drive(0, 0, 0, 0, 3'd0, 0); tick();
      chk("fire_exit", 8'(state), 8'd0);
      repeat (3) tick();

      // Reset in the middle of an unlock window.
      drive(0, 0, 1, 1, 3'd0, 0); tick();
      drive(0, 0, 0, 0, 3'd0, 0); tick(); tick();
      drive(1, 0, 0, 0, 3'd0, 0); tick();
      chk("rst_door", 8'(door_unlock), 8'd0);
      drive(0, 0, 0, 0, 3'd0, 0); tick();

      // Below-threshold wrong attempt changes nothing.
      drive(0, 0, 1, 0, 3'd2, 0); tick();
      chk("below_thresh", 8'(state), 8'd0);

      // Reset beats fire; fire taken on the first edge after reset falls.
      drive(1, 1, 0, 0, 3'd0, 0); tick();
      chk("rst_over_fire", 8'(state), 8'd0);
      drive(0, 1, 0, 0, 3'd0, 0); tick();
      drive(0, 0, 0, 0, 3'd0, 0); tick();

      // Fire during alarm (count=7): no O2, then IDLE even with disarm high.
      drive(0, 0, 1, 0, 3'd7, 0); tick();
      chk("count7_alarm", 8'(state), 8'd3);
      drive(0, 1, 0, 0, 3'd0, 1); tick();
      drive(0, 0, 0, 0, 3'd0, 1); tick();
      chk("fire_from_alarm", 8'(state), 8'd0);
      drive(0, 0, 0, 0, 3'd0, 0); tick();

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
